lfsr_err_inject: RTL
====================

LFSR_ERR_INJECT -- requirements
Module: lfsr_err_inject

Interface
REQ-001 Parameters SHALL be exactly as follows.
- DataBits, default 32: stream data width.
- ErrPeriod, default 8: one beat in every ErrPeriod accepted beats is corrupted; legal range is 1..65535.
- ErrMask, default 32'h98000023: XOR mask applied to a corrupted beat, DataBits wide.
- CountBits, default 32: width of err_count.

REQ-002 Ports SHALL be exactly as follows; the block has one clock, and reset is synchronous and active-low.
- clk  in  1  sole clock.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  injection enable, sampled on each accepted beat.
- din_valid  in  1  upstream beat valid.
- din_ready  out  1  upstream ready, registered.
- din_data  in  DataBits  upstream data.
- din_eof  in  1  upstream end-of-frame.
- dout_valid  out  1  downstream beat valid, registered.
- dout_ready  in  1  downstream ready.
- dout_data  out  DataBits  data, possibly corrupted.
- dout_eof  out  1  end-of-frame, passed through unchanged.
- inj_pulse  out  1  one-cycle strobe when a corrupted beat is accepted at din.
- err_count  out  CountBits  saturating count of injected beats.

Function
REQ-003 A beat SHALL transfer on din when din_valid && din_ready, and on dout when dout_valid && dout_ready, both at the rising edge of clk.
REQ-004 The datapath SHALL be a 2-entry skid buffer: one output register plus one skid register.
REQ-005 Latency SHALL be 1 cycle from din acceptance to dout_valid when the buffer is empty.
REQ-006 Throughput SHALL be 1 beat/cycle while dout_ready=1.
REQ-007 din_ready SHALL equal NOT skid_full, taken from a register with no combinational path from dout_ready.
REQ-008 When the output register holds a beat and dout_ready=0, a beat accepted at din SHALL go to the skid register, and din_ready SHALL drop the next cycle.
REQ-009 When dout fires while the skid register is full, the skid contents SHALL move to the output register and din_ready SHALL rise the next cycle.
REQ-010 Beat order SHALL be preserved; no beat is dropped or duplicated.
REQ-011 dout_valid, dout_data and dout_eof SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-012 beat_cnt, an internal counter of ceil(log2(ErrPeriod)) bits (minimum 1), SHALL increment on every din acceptance regardless of en and din_eof.
REQ-013 beat_cnt SHALL wrap from ErrPeriod-1 to 0 and SHALL NOT advance without a din acceptance.
REQ-014 An accepted beat SHALL be corrupted iff en=1 and beat_cnt==ErrPeriod-1 at acceptance; the stored data is then din_data XOR ErrMask.
REQ-015 dout_eof SHALL never be modified.
REQ-016 With ErrPeriod=1, every beat accepted while en=1 SHALL be corrupted.
REQ-017 inj_pulse SHALL be asserted in the cycle after each corrupted acceptance, for exactly 1 cycle per corrupted beat.
REQ-018 err_count SHALL increment by 1 in the same cycle inj_pulse asserts.
REQ-019 err_count SHALL saturate at 2^CountBits-1 and not wrap.
REQ-020 A change of en SHALL affect only beats accepted after the change; beats already buffered keep their data.
REQ-021 Simultaneous din and dout transfers SHALL leave occupancy unchanged.

Reset
REQ-022 While rst_n=0 at a clock edge, the following SHALL be 0 after that edge: dout_valid, dout_data, dout_eof, din_ready, inj_pulse, err_count, beat_cnt and skid_full.
REQ-023 din_ready SHALL be 1 in the first cycle after rst_n returns to 1.
REQ-024 Reset asserted mid-stream SHALL discard all buffered beats without presenting them on dout.
REQ-025 beat_cnt SHALL restart at 0 after reset, so the first corrupted beat is the ErrPeriod-th beat accepted after reset.

Verification
REQ-026 Basic injection: defaults, en=1, dout_ready=1, din_data=0..15 back-to-back -> dout_data equals din_data, except beat 7 = 0x98000024 and beat 15 = 0x9800002C; each beat appears 1 cycle after acceptance; err_count=2; inj_pulse is high for 2 cycles total.
REQ-027 Backpressure: 20 incrementing beats, dout_ready low for 3 cycles starting at beat 4 -> din_ready low from the second stalled cycle; output sequence complete, in order, with no duplicates; beats 7 and 15 corrupted; dout held stable while stalled.
REQ-028 Enable off: en=0 for 16 beats -> no corruption, err_count=0, inj_pulse never high; beat_cnt still advances, so with en=1 from beat 16, beat 23 is corrupted.
REQ-029 Reset mid-stream: rst_n low for 1 cycle while dout stalled with both registers full -> next cycle dout_valid=0 and din_ready=0, then din_ready=1; the next 8 beats end with beat 8 corrupted; err_count is 0 before that corruption.
REQ-030 Edge parameters: ErrPeriod=1 and CountBits=2, 6 beats with en=1 -> all 6 equal data XOR ErrMask; err_count reads 1, 2, 3, 3, 3, 3.

Source files
------------

// File: rtl/lfsr_err_inject.sv
// lfsr_err_inject: 2-entry skid buffer that XOR-corrupts one beat in
// every ErrPeriod accepted beats and keeps a saturating injection count.
module lfsr_err_inject #(
   parameter int unsigned         DataBits  = 32,
   parameter int unsigned         ErrPeriod = 8,
   parameter logic [DataBits-1:0] ErrMask   = 32'h98000023,
   parameter int unsigned         CountBits = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 din_valid,
   output logic                 din_ready,
   input  logic [DataBits-1:0]  din_data,
   input  logic                 din_eof,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic [DataBits-1:0]  dout_data,
   output logic                 dout_eof,
   output logic                 inj_pulse,
   output logic [CountBits-1:0] err_count
);

   localparam int unsigned CntW = (ErrPeriod > 1) ? $clog2(ErrPeriod) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(ErrPeriod - 1);

   logic                 out_valid_q, out_valid_d;
   logic [DataBits-1:0]  out_data_q, out_data_d;
   logic                 out_eof_q, out_eof_d;
   logic                 skid_full_q, skid_full_d;
   logic [DataBits-1:0]  skid_data_q, skid_data_d;
   logic                 skid_eof_q, skid_eof_d;
   logic                 ready_q, ready_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 inj_q, inj_d;
   logic [CountBits-1:0] err_q, err_d;

   logic                din_fire;
   logic                dout_fire;
   logic                corrupt;
   logic [DataBits-1:0] in_data;

   always_comb begin
      din_fire    = din_valid && ready_q;
      dout_fire   = out_valid_q && dout_ready;
      corrupt     = en && (cnt_q == LastCnt);
      in_data     = corrupt ? (din_data ^ ErrMask) : din_data;

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_eof_d   = out_eof_q;
      skid_full_d = skid_full_q;
      skid_data_d = skid_data_q;
      skid_eof_d  = skid_eof_q;

      // ready_q is low whenever the skid holds a beat, so din cannot fire here
      if (skid_full_q) begin
         if (dout_fire) begin
            out_data_d  = skid_data_q;
            out_eof_d   = skid_eof_q;
            skid_full_d = 1'b0;
         end
      end else if (din_fire) begin
         if (out_valid_q && !dout_ready) begin
            skid_data_d = in_data;
            skid_eof_d  = din_eof;
            skid_full_d = 1'b1;
         end else begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_eof_d   = din_eof;
         end
      end else if (dout_fire) begin
         out_valid_d = 1'b0;
      end

      ready_d = !skid_full_d;

      cnt_d = cnt_q;
      if (din_fire) begin
         cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
      end

      inj_d = din_fire && corrupt;
      err_d = err_q;
      if (inj_d && (err_q != '1)) begin
         err_d = err_q + CountBits'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_eof_q   <= 1'b0;
         skid_full_q <= 1'b0;
         skid_data_q <= '0;
         skid_eof_q  <= 1'b0;
         ready_q     <= 1'b0;
         cnt_q       <= '0;
         inj_q       <= 1'b0;
         err_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_eof_q   <= out_eof_d;
         skid_full_q <= skid_full_d;
         skid_data_q <= skid_data_d;
         skid_eof_q  <= skid_eof_d;
         ready_q     <= ready_d;
         cnt_q       <= cnt_d;
         inj_q       <= inj_d;
         err_q       <= err_d;
      end
   end

   assign din_ready  = ready_q;
   assign dout_valid = out_valid_q;
   assign dout_data  = out_data_q;
   assign dout_eof   = out_eof_q;
   assign inj_pulse  = inj_q;
   assign err_count  = err_q;

endmodule
